// File: rtl/io_counter_monitor.sv
`timescale 1ns/1ps
// io_counter_monitor
// Watches a binary counter arriving on io_in. The raw pins are synchronized,
// and a stability filter removes glitches. Each value the filter accepts is
// checked against the previous value + 1 (mod 2^WIDTH). The block counts
// correct steps and bad steps, reports lock status, and raises a sticky
// interrupt.
// Optional build macro: COUNTER_MON_STALL_DETECT_EN adds the inactivity
// timer and the STALLED state. Without it, LOCKED never times out.
module io_counter_monitor #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int TIMEOUT       = 1024,
  parameter int CNT_W         = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_oeb,
  output logic [WIDTH-1:0] value_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] inc_count_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic             locked_o,
  output logic             irq_o
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0]    STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0]    STAB_ONE = SW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef COUNTER_MON_STALL_DETECT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_STALLED = 2'd3
  } state_t;

  logic [TW-1:0] r_timer;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // The timeout has no meaning without stall detection; it is only tied off here.
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT);
`endif

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_cand;
  logic [SW-1:0]    r_stab;
  logic             r_fired;
  logic [WIDTH-1:0] r_value;
  logic             r_valid;
  logic [CNT_W-1:0] r_inc;
  logic [CNT_W-1:0] r_err;
  logic             r_locked;
  logic             r_irq;

  logic             w_stab_hit;
  logic [WIDTH-1:0] w_value_inc;
  logic             w_load;
  logic             w_inc_evt;
  logic             w_err_evt;
  logic             w_stall_evt;

  // The pads are always inputs.
  assign io_oeb = {WIDTH{1'b1}};

  assign value_o     = r_value;
  assign valid_o     = r_valid;
  assign inc_count_o = r_inc;
  assign err_count_o = r_err;
  assign locked_o    = r_locked;
  assign irq_o       = r_irq;

  // The candidate fires once, on the first cycle that its stability count is full.
  assign w_stab_hit  = en_i && (r_stab == STAB_MAX) && !r_fired;
  assign w_value_inc = r_value + WIDTH'(1);

  // Two-flop synchronizer on the raw pins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_s1 <= {WIDTH{1'b0}};
      r_s2 <= {WIDTH{1'b0}};
    end else begin
      r_s1 <= io_in;
      r_s2 <= r_s1;
    end
  end

  // Stability filter: count consecutive identical synchronized samples.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_cand  <= {WIDTH{1'b0}};
      r_stab  <= {SW{1'b0}};
      r_fired <= 1'b0;
    end else if (!en_i) begin
      r_cand  <= {WIDTH{1'b0}};
      r_stab  <= {SW{1'b0}};
      r_fired <= 1'b0;
    end else if (r_s2 != r_cand) begin
      r_cand  <= r_s2;
      r_stab  <= STAB_ONE;
      r_fired <= 1'b0;
    end else begin
      if (r_stab < STAB_MAX) begin
        r_stab <= r_stab + STAB_ONE;
      end
      if (w_stab_hit) begin
        r_fired <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and event decode. Every event is held off while disabled.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_inc_evt   = 1'b0;
    w_err_evt   = 1'b0;
    w_stall_evt = 1'b0;
    if (!en_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (w_stab_hit) begin
            w_load      = 1'b1;
            w_state_nxt = ST_LOCKED;
          end else begin
            w_state_nxt = ST_ACQUIRE;
          end
        end
        ST_LOCKED: begin
          if (w_stab_hit && (r_cand != r_value)) begin
            w_load      = 1'b1;
            w_state_nxt = ST_LOCKED;
            if (r_cand == w_value_inc) begin
              w_inc_evt = 1'b1;
            end else begin
              w_err_evt = 1'b1;
            end
          end
`ifdef COUNTER_MON_STALL_DETECT_EN
          else if (r_timer == TMO_LAST) begin
            w_stall_evt = 1'b1;
            w_state_nxt = ST_STALLED;
          end
`endif
          else begin
            w_state_nxt = ST_LOCKED;
          end
        end
`ifdef COUNTER_MON_STALL_DETECT_EN
        ST_STALLED: begin
          if (w_stab_hit) begin
            w_load      = 1'b1;
            w_state_nxt = ST_LOCKED;
          end else begin
            w_state_nxt = ST_STALLED;
          end
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

`ifdef COUNTER_MON_STALL_DETECT_EN
  // Inactivity timer. It runs only while LOCKED persists with no accepted value.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_timer <= {TW{1'b0}};
    end else if ((r_state == ST_LOCKED) && (w_state_nxt == ST_LOCKED) && !w_load) begin
      r_timer <= r_timer + TMO_ONE;
    end else begin
      r_timer <= {TW{1'b0}};
    end
  end
`endif

  // Accepted value, valid pulse and lock flag.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_value  <= {WIDTH{1'b0}};
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_valid  <= w_load;
      r_locked <= (w_state_nxt == ST_LOCKED);
      if (w_load) begin
        r_value <= r_cand;
      end
    end
  end

  // Saturating step counters. A clear wins over a same-cycle event.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_inc <= {CNT_W{1'b0}};
      r_err <= {CNT_W{1'b0}};
    end else if (clr_i) begin
      r_inc <= {CNT_W{1'b0}};
      r_err <= {CNT_W{1'b0}};
    end else begin
      if (w_inc_evt && (r_inc != CNT_MAX)) begin
        r_inc <= r_inc + CNT_ONE;
      end
      if (w_err_evt && (r_err != CNT_MAX)) begin
        r_err <= r_err + CNT_ONE;
      end
    end
  end

  // Sticky interrupt on a step error or a stall. A clear wins over a same-cycle set.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_irq <= 1'b0;
    end else if (clr_i) begin
      r_irq <= 1'b0;
    end else if (w_err_evt || w_stall_evt) begin
      r_irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_counter_monitor.sv
`timescale 1ns/1ps
// Self-checking bench for io_counter_monitor. A scoreboard queue holds the
// expected result of each accepted value. One extra instance with 4-bit
// counters is used to check that the error counter saturates.
module tb_io_counter_monitor;

  logic        clk_s = 1'b0;
  logic        rst_n_s;
  logic        en_s;
  logic        clr_s;
  logic [3:0]  io_in_s;
  logic [3:0]  oeb_s;
  logic [3:0]  value_s;
  logic        valid_s;
  logic [15:0] inc_s;
  logic [15:0] err_s;
  logic        locked_s;
  logic        irq_s;

  logic [3:0]  unused_sat_oeb;
  logic [3:0]  unused_sat_value;
  logic        unused_sat_valid;
  logic [3:0]  unused_sat_inc;
  logic [3:0]  err_sat_s;
  logic        unused_sat_locked;
  logic        unused_sat_irq;

  typedef struct {
    logic [3:0]  value;
    logic [15:0] inc;
    logic [15:0] err;
    logic        irq;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_valid = 0;

  logic        m_acq;
  logic [3:0]  m_value;
  logic [15:0] m_inc;
  logic [15:0] m_err;
  logic        m_irq;

  io_counter_monitor u_dut (
    .wb_clk_i    (clk_s),
    .wb_rst_n_i  (rst_n_s),
    .en_i        (en_s),
    .clr_i       (clr_s),
    .io_in       (io_in_s),
    .io_oeb      (oeb_s),
    .value_o     (value_s),
    .valid_o     (valid_s),
    .inc_count_o (inc_s),
    .err_count_o (err_s),
    .locked_o    (locked_s),
    .irq_o       (irq_s)
  );

  io_counter_monitor #(.CNT_W(4)) u_dut_sat (
    .wb_clk_i    (clk_s),
    .wb_rst_n_i  (rst_n_s),
    .en_i        (en_s),
    .clr_i       (clr_s),
    .io_in       (io_in_s),
    .io_oeb      (unused_sat_oeb),
    .value_o     (unused_sat_value),
    .valid_o     (unused_sat_valid),
    .inc_count_o (unused_sat_inc),
    .err_count_o (err_sat_s),
    .locked_o    (unused_sat_locked),
    .irq_o       (unused_sat_irq)
  );

  // Free-running clock.
  always #5 clk_s = ~clk_s;

  // Cycle counter used to check accept latency.
  always @(posedge clk_s) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_s);
    #1;
  endtask

  task automatic model_clear();
    m_inc = 16'd0;
    m_err = 16'd0;
    m_irq = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_s = 1'b1;
    wait_cyc(1);
    clr_s = 1'b0;
    model_clear();
  endtask

  // Drive a value and hold it for 8 cycles. Any expected accept is pushed to the
  // scoreboard. With clr_acc set, clr_i is pulsed on the accept edge.
  task automatic drive_val(input logic [3:0] v, input bit lat, input bit clr_acc);
    exp_t e;
    bit   acc;
    int   dcyc;
    io_in_s = v;
    dcyc = cyc;
    acc  = 1'b0;
    if (m_acq) begin
      acc   = 1'b1;
      m_acq = 1'b0;
    end else if (v != m_value) begin
      acc = 1'b1;
      if (v == 4'(m_value + 4'd1)) begin
        if (m_inc != 16'hFFFF) m_inc = m_inc + 16'd1;
      end else begin
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        m_irq = 1'b1;
      end
    end
    if (clr_acc) model_clear();
    if (acc) begin
      m_value = v;
      e.value = v;
      e.inc   = m_inc;
      e.err   = m_err;
      e.irq   = m_irq;
      e.cyc   = lat ? dcyc + 6 : 0;
      sb_q.push_back(e);
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_s);
      #1;
      clr_s = (clr_acc && (cyc == dcyc + 5)) ? 1'b1 : 1'b0;
    end
    clr_s = 1'b0;
  endtask

  // Output monitor: pop the scoreboard on every valid pulse.
  always @(negedge clk_s) begin
    if (rst_n_s && valid_s) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        check_val("unexp_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("sb_value", 32'(value_s), 32'(mon_e.value));
        check_val("sb_inc", 32'(inc_s), 32'(mon_e.inc));
        check_val("sb_err", 32'(err_s), 32'(mon_e.err));
        check_val("sb_irq", 32'(irq_s), 32'(mon_e.irq));
        check_val("sb_locked", 32'(locked_s), 32'd1);
        if (mon_e.cyc != 0) check_val("sb_latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    int nv;
    logic [3:0] v;
    rst_n_s = 1'b0;
    en_s    = 1'b0;
    clr_s   = 1'b0;
    io_in_s = 4'd0;
    m_acq   = 1'b1;
    m_value = 4'd0;
    model_clear();

    repeat (3) @(posedge clk_s);
    @(negedge clk_s);
    check_val("rst_value", 32'(value_s), 32'd0);
    check_val("rst_valid", 32'(valid_s), 32'd0);
    check_val("rst_inc", 32'(inc_s), 32'd0);
    check_val("rst_err", 32'(err_s), 32'd0);
    check_val("rst_locked", 32'(locked_s), 32'd0);
    check_val("rst_irq", 32'(irq_s), 32'd0);
    check_val("rst_oeb", 32'(oeb_s), 32'hF);

    en_s = 1'b1;
    wait_cyc(1);
    rst_n_s = 1'b1;

    // Count 0..19 (mod 16). This includes the 15 -> 0 wrap.
    drive_val(4'd0, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) drive_val(4'(i), 1'b1, 1'b0);
    check_val("run_inc", 32'(inc_s), 32'd19);
    check_val("run_err", 32'(err_s), 32'd0);
    check_val("run_locked", 32'(locked_s), 32'd1);
    check_val("run_irq", 32'(irq_s), 32'd0);
    check_val("run_nvalid", 32'(n_valid), 32'd20);

    // Bad step 5 -> 9, then good step 9 -> 10, then clear.
    drive_val(4'd4, 1'b1, 1'b0);
    drive_val(4'd5, 1'b1, 1'b0);
    drive_val(4'd9, 1'b1, 1'b0);
    check_val("bad_err", 32'(err_s), 32'd1);
    check_val("bad_irq", 32'(irq_s), 32'd1);
    check_val("bad_value", 32'(value_s), 32'd9);
    drive_val(4'd10, 1'b1, 1'b0);
    check_val("good_inc", 32'(inc_s), 32'd22);
    pulse_clr();
    check_val("clr_inc", 32'(inc_s), 32'd0);
    check_val("clr_err", 32'(err_s), 32'd0);
    check_val("clr_irq", 32'(irq_s), 32'd0);

    // Glitches of 1 and 2 cycles are filtered out. A held value is accepted.
    nv = n_valid;
    io_in_s = 4'd11; wait_cyc(1); io_in_s = 4'd10; wait_cyc(8);
    io_in_s = 4'd11; wait_cyc(2); io_in_s = 4'd10; wait_cyc(8);
    check_val("glitch_nvalid", 32'(n_valid), 32'(nv));
    check_val("glitch_inc", 32'(inc_s), 32'd0);
    check_val("glitch_value", 32'(value_s), 32'd10);
    drive_val(4'd11, 1'b1, 1'b0);
    check_val("hold_inc", 32'(inc_s), 32'd1);

    // Hold a constant value for a long time.
    wait_cyc(1100);
`ifdef COUNTER_MON_STALL_DETECT_EN
    check_val("stall_locked", 32'(locked_s), 32'd0);
    check_val("stall_irq", 32'(irq_s), 32'd1);
    m_acq = 1'b1;
    m_irq = 1'b1;
`else
    check_val("nostall_locked", 32'(locked_s), 32'd1);
    check_val("nostall_irq", 32'(irq_s), 32'd0);
`endif
    drive_val(4'd12, 1'b1, 1'b0);
    check_val("relock_err", 32'(err_s), 32'd0);
    check_val("relock_locked", 32'(locked_s), 32'd1);
    pulse_clr();

    // A clear on the same cycle as an error accept drops the error.
    drive_val(4'd3, 1'b1, 1'b1);
    check_val("clrerr_err", 32'(err_s), 32'd0);
    check_val("clrerr_irq", 32'(irq_s), 32'd0);
    check_val("clrerr_value", 32'(value_s), 32'd3);

    // Disable mid-stream, then re-enable and re-acquire without counting.
    drive_val(4'd4, 1'b1, 1'b0);
    en_s = 1'b0;
    wait_cyc(3);
    check_val("dis_locked", 32'(locked_s), 32'd0);
    check_val("dis_value", 32'(value_s), 32'd4);
    check_val("dis_inc", 32'(inc_s), 32'd1);
    nv = n_valid;
    io_in_s = 4'd9;
    wait_cyc(8);
    check_val("dis_nvalid", 32'(n_valid), 32'(nv));
    en_s  = 1'b1;
    m_acq = 1'b1;
    drive_val(4'd9, 1'b0, 1'b0);
    check_val("reacq_value", 32'(value_s), 32'd9);
    check_val("reacq_inc", 32'(inc_s), 32'd1);
    check_val("reacq_err", 32'(err_s), 32'd0);
    check_val("reacq_locked", 32'(locked_s), 32'd1);

    // 17 bad steps: the 4-bit error counter holds at 15.
    pulse_clr();
    v = 4'd9;
    for (int i = 0; i < 17; i++) begin
      v = v + 4'd2;
      drive_val(v, 1'b1, 1'b0);
    end
    check_val("sat_err16", 32'(err_s), 32'd17);
    check_val("sat_err4", 32'(err_sat_s), 32'd15);
    check_val("sat_irq", 32'(irq_s), 32'd1);

    // Reset mid-operation.
    rst_n_s = 1'b0;
    #2;
    check_val("mrst_value", 32'(value_s), 32'd0);
    check_val("mrst_locked", 32'(locked_s), 32'd0);
    check_val("mrst_err", 32'(err_s), 32'd0);
    check_val("mrst_irq", 32'(irq_s), 32'd0);
    wait_cyc(2);
    rst_n_s = 1'b1;
    m_acq   = 1'b1;
    m_value = 4'd0;
    model_clear();
    drive_val(4'd5, 1'b0, 1'b0);
    check_val("mrst_acq_value", 32'(value_s), 32'd5);
    check_val("mrst_acq_inc", 32'(inc_s), 32'd0);
    check_val("mrst_acq_locked", 32'(locked_s), 32'd1);

    wait_cyc(10);
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
